// File: rtl/song_bank_pkg.sv
// Shared types and helpers for the song slot bank: FSM states, command
// priority encoding and derived-width functions.
package song_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REC   = 2'd1,
      FETCH = 2'd2,
      PLAY  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE    = 3'd0,
      CMD_DISCARD = 3'd1,
      CMD_SAVE    = 3'd2,
      CMD_DEL     = 3'd3,
      CMD_REC     = 3'd4,
      CMD_PLAY    = 3'd5
   } cmd_t;

   function automatic int slot_width(input int slots);
      return $clog2(slots);
   endfunction

   // One extra bit so a full slot length of DEPTH is representable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Coinciding command pulses resolve to the single highest-priority one.
   function automatic cmd_t cmd_pick(input logic discard, input logic save,
                                     input logic del, input logic rec,
                                     input logic play);
      cmd_t c;
      if (discard)   c = CMD_DISCARD;
      else if (save) c = CMD_SAVE;
      else if (del)  c = CMD_DEL;
      else if (rec)  c = CMD_REC;
      else if (play) c = CMD_PLAY;
      else           c = CMD_NONE;
      return c;
   endfunction

endpackage

// File: rtl/slot_alloc.sv
// Lowest-free-slot priority encoder; preloaded slots below PRE_SLOTS are
// never offered for allocation.
module slot_alloc #(
   parameter int SLOTS     = 8,
   parameter int PRE_SLOTS = 3,
   parameter int SLOT_W    = 3
) (
   input  logic [SLOTS-1:0]  used_mask,
   output logic [SLOT_W-1:0] free_idx,
   output logic              none_free
);

   // Scan top-down so the lowest free index is the last one written.
   always_comb begin
      free_idx  = '0;
      none_free = 1'b1;
      for (int i = SLOTS - 1; i >= PRE_SLOTS; i--) begin
         free_idx  = used_mask[i] ? free_idx : SLOT_W'(i);
         none_free = none_free & used_mask[i];
      end
   end

endmodule

// File: rtl/song_slot_bank.sv
// Parametrised song slot store: record/save/discard/delete/play sequenced by
// one FSM. Optional endless playback loop: SONG_SLOT_BANK_LOOP_PLAY_EN.
module song_slot_bank
   import song_bank_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int SLOTS     = 8,
   parameter int DEPTH     = 256,
   parameter int PRE_SLOTS = 3,
   parameter int SLOT_W    = slot_width(SLOTS),
   parameter int PTR_W     = ptr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_rec,
   input  logic              cmd_save,
   input  logic              cmd_discard,
   input  logic              cmd_del,
   input  logic              cmd_play,
   input  logic [SLOT_W-1:0] sel,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic              full,
   output logic [SLOT_W:0]   count,
   output logic [SLOTS-1:0]  used_mask,
   output logic [SLOT_W-1:0] rec_slot,
   output logic [PTR_W-1:0]  rec_len,
   output logic              overflow,
   output logic              err
);

   localparam int AW = SLOT_W + PTR_W - 1;
   localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1'b1);
   localparam logic [SLOT_W:0]   CNT_ONE = (SLOT_W + 1)'(1'b1);
   localparam logic [SLOT_W:0]   SLOTS_C = (SLOT_W + 1)'(SLOTS);
   localparam logic [SLOT_W:0]   PRE_CNT = (SLOT_W + 1)'(PRE_SLOTS);
   localparam logic [SLOT_W-1:0] PRE_IDX = SLOT_W'(PRE_SLOTS);

   state_t            state_r;
   logic [PTR_W-1:0]  ptr_r;
   logic [PTR_W-1:0]  slot_len_r [SLOTS];
   logic [DATA_W-1:0] mem_r [0:(1 << AW) - 1];

   cmd_t              cmd_s;
   logic              busy_cmd_s;
   logic              len_full_s;
   logic              wr_ok_s;
   logic [PTR_W-1:0]  len_next_s;
   logic              play_last_s;
   logic [AW-1:0]     wr_addr_s;
   logic [AW-1:0]     rd_addr_s;
   logic [SLOT_W-1:0] free_idx_s;
   logic              none_free_s;

   assign cmd_s       = cmd_pick(cmd_discard, cmd_save, cmd_del, cmd_rec, cmd_play);
   // Commands that are only legal in IDLE; elsewhere they are rejected.
   assign busy_cmd_s  = (cmd_s == CMD_DEL) || (cmd_s == CMD_REC) || (cmd_s == CMD_PLAY);
   assign len_full_s  = (rec_len == DEPTH_P);
   assign wr_ok_s     = (state_r == REC) && wr_valid && !len_full_s;
   assign len_next_s  = wr_ok_s ? (rec_len + PTR_ONE) : rec_len;
   assign play_last_s = (ptr_r == (slot_len_r[rec_slot] - PTR_ONE));
   assign wr_addr_s   = {rec_slot, rec_len[PTR_W-2:0]};
   assign rd_addr_s   = {rec_slot, ptr_r[PTR_W-2:0]};

   slot_alloc #(
      .SLOTS     (SLOTS),
      .PRE_SLOTS (PRE_SLOTS),
      .SLOT_W    (SLOT_W)
   ) u_alloc (
      .used_mask (used_mask),
      .free_idx  (free_idx_s),
      .none_free (none_free_s)
   );

   // Note array write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_addr_s] <= wr_data;
      end
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         ptr_r    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
         busy     <= 1'b0;
         full     <= 1'b0;
         count    <= PRE_CNT;
         rec_slot <= '0;
         rec_len  <= '0;
         overflow <= 1'b0;
         err      <= 1'b0;
         for (int i = 0; i < SLOTS; i++) begin
            used_mask[i]  <= (i < PRE_SLOTS);
            slot_len_r[i] <= (i < PRE_SLOTS) ? DEPTH_P : '0;
         end
      end else begin
         err <= 1'b0;
         case (state_r)
            IDLE: begin
               case (cmd_s)
                  CMD_DEL: begin
                     if ((sel < PRE_IDX) || !used_mask[sel]) begin
                        err <= 1'b1;
                     end else begin
                        used_mask[sel]  <= 1'b0;
                        slot_len_r[sel] <= '0;
                        count           <= count - CNT_ONE;
                        full            <= 1'b0;
                     end
                  end
                  CMD_REC: begin
                     if (full || none_free_s) begin
                        err <= 1'b1;
                     end else begin
                        rec_slot <= free_idx_s;
                        rec_len  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= REC;
                     end
                  end
                  CMD_PLAY: begin
                     if (!used_mask[sel] || (slot_len_r[sel] == '0)) begin
                        err <= 1'b1;
                     end else begin
                        rec_slot <= sel;
                        ptr_r    <= '0;
                        busy     <= 1'b1;
                        state_r  <= FETCH;
                     end
                  end
                  default: ;
               endcase
            end
            REC: begin
               rec_len <= len_next_s;
               if (wr_valid && len_full_s) begin
                  overflow <= 1'b1;
               end
               case (cmd_s)
                  CMD_DISCARD: begin
                     busy    <= 1'b0;
                     state_r <= IDLE;
                  end
                  CMD_SAVE: begin
                     // A note arriving with the save is part of the commit.
                     slot_len_r[rec_slot] <= len_next_s;
                     used_mask[rec_slot]  <= 1'b1;
                     count                <= count + CNT_ONE;
                     full                 <= ((count + CNT_ONE) == SLOTS_C);
                     busy                 <= 1'b0;
                     state_r              <= IDLE;
                  end
                  default: err <= busy_cmd_s;
               endcase
            end
            FETCH: begin
               if (cmd_s == CMD_DISCARD) begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  err      <= busy_cmd_s;
                  rd_data  <= mem_r[rd_addr_s];
                  rd_last  <= play_last_s;
                  rd_valid <= 1'b1;
                  state_r  <= PLAY;
               end
            end
            PLAY: begin
               if (cmd_s == CMD_DISCARD) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  busy     <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  err <= busy_cmd_s;
                  if (rd_ready) begin
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                     if (rd_last) begin
`ifdef SONG_SLOT_BANK_LOOP_PLAY_EN
                        ptr_r   <= '0;
                        state_r <= FETCH;
`else
                        busy    <= 1'b0;
                        state_r <= IDLE;
`endif
                     end else begin
                        ptr_r   <= ptr_r + PTR_ONE;
                        state_r <= FETCH;
                     end
                  end
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_slot_bank.sv
// Self-checking bench for song_slot_bank (default parameters); expected
// playback records are queued as notes are written and popped on handshake.
module tb_song_slot_bank;

   localparam int DEPTH = 256;
   localparam int C_DIS = 0, C_SAVE = 1, C_DEL = 2, C_REC = 3, C_PLAY = 4;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk, rst_n;
   logic       cmd_rec, cmd_save, cmd_discard, cmd_del, cmd_play;
   logic [2:0] sel;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       rd_valid, rd_ready, rd_last;
   logic [7:0] rd_data;
   logic       busy, full, overflow, err;
   logic [3:0] count;
   logic [7:0] used_mask;
   logic [2:0] rec_slot;
   logic [8:0] rec_len;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   logic [7:0] slot3_notes [3];

   song_slot_bank dut (
      .clk(clk), .rst_n(rst_n), .cmd_rec(cmd_rec), .cmd_save(cmd_save),
      .cmd_discard(cmd_discard), .cmd_del(cmd_del), .cmd_play(cmd_play),
      .sel(sel), .wr_valid(wr_valid), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_last(rd_last), .busy(busy), .full(full), .count(count),
      .used_mask(used_mask), .rec_slot(rec_slot), .rec_len(rec_len),
      .overflow(overflow), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input int k, input logic [2:0] s);
      sel = s;
      case (k)
         C_DIS:   cmd_discard = 1'b1;
         C_SAVE:  cmd_save    = 1'b1;
         C_DEL:   cmd_del     = 1'b1;
         C_REC:   cmd_rec     = 1'b1;
         default: cmd_play    = 1'b1;
      endcase
      tick();
      {cmd_discard, cmd_save, cmd_del, cmd_rec, cmd_play} = 5'b0;
   endtask

   task automatic write_note(input logic [7:0] d, input logic last);
      exp_t e;
      wr_valid = 1'b1;
      wr_data  = d;
      e.data   = d;
      e.last   = last;
      sb.push_back(e);
      tick();
      wr_valid = 1'b0;
   endtask

   // Consume queued expectations with rd_ready high.
   task automatic drain(input string name);
      exp_t e;
      rd_ready = 1'b1;
      for (int c = 0; c < 200 && sb.size() > 0; c++) begin
         if (rd_valid) begin
            e = sb.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_last !== e.last) begin
               n_errors++;
               $display("FAIL %s: data=%0h last=%0b expected data=%0h last=%0b",
                        name, rd_data, rd_last, e.data, e.last);
            end
         end
         tick();
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL %s_timeout: %0d records left, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic finish_play(input string name);
`ifdef SONG_SLOT_BANK_LOOP_PLAY_EN
      cmd(C_DIS, 3'd0);
`endif
      n_checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL %s_end: busy=%0b rd_valid=%0b expected 0 0", name, busy, rd_valid);
      end
   endtask

   task automatic wait_valid(input string name);
      for (int c = 0; c < 10 && !rd_valid; c++) tick();
      n_checks++;
      if (rd_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_wait: rd_valid=%0b expected 1", name, rd_valid);
      end
   endtask

   task automatic push_slot3();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.data = slot3_notes[i];
         e.last = (i == 2);
         sb.push_back(e);
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (used_mask !== 8'b00000111 || count !== 4'd3 || full !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_slots: mask=%b count=%0d full=%0b expected 00000111 3 0",
                  used_mask, count, full);
      end
      n_checks++;
      if ({busy, rd_valid, rd_last, rd_data, rec_slot, rec_len, overflow, err} !== 23'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: busy=%0b rdv=%0b data=%0h slot=%0d len=%0d ovf=%0b err=%0b expected all 0",
                  busy, rd_valid, rd_data, rec_slot, rec_len, overflow, err);
      end
      cmd(C_DEL, 3'd1);
      n_checks++;
      if (err !== 1'b1 || used_mask !== 8'b00000111) begin
         n_errors++;
         $display("FAIL del_protected: err=%0b mask=%b expected 1 00000111", err, used_mask);
      end
      tick();
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++;
         $display("FAIL err_pulse: err=%0b expected 0", err);
      end
   endtask

   task automatic test_record_play();
      cmd(C_REC, 3'd0);
      n_checks++;
      if (busy !== 1'b1 || rec_slot !== 3'd3 || rec_len !== 9'd0) begin
         n_errors++;
         $display("FAIL rec_start: busy=%0b slot=%0d len=%0d expected 1 3 0", busy, rec_slot, rec_len);
      end
      for (int i = 0; i < 3; i++) write_note(slot3_notes[i], i == 2);
      n_checks++;
      if (rec_len !== 9'd3) begin
         n_errors++;
         $display("FAIL rec_len: got %0d expected 3", rec_len);
      end
      cmd(C_SAVE, 3'd0);
      n_checks++;
      if (count !== 4'd4 || used_mask !== 8'h0F || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL save: count=%0d mask=%b busy=%0b expected 4 00001111 0", count, used_mask, busy);
      end
      rd_ready = 1'b1;
      cmd(C_PLAY, 3'd3);
      drain("play3");
      finish_play("play3");
   endtask

   task automatic test_fill_full();
      for (int s = 4; s < 8; s++) begin
         cmd(C_REC, 3'd0);
         n_checks++;
         if (rec_slot !== 3'(s)) begin
            n_errors++;
            $display("FAIL fill_slot: got %0d expected %0d", rec_slot, s);
         end
         wr_valid = 1'b1;
         wr_data  = 8'(s);
         tick();
         wr_valid = 1'b0;
         cmd(C_SAVE, 3'd0);
      end
      n_checks++;
      if (count !== 4'd8 || full !== 1'b1 || used_mask !== 8'hFF) begin
         n_errors++;
         $display("FAIL full: count=%0d full=%0b mask=%b expected 8 1 11111111", count, full, used_mask);
      end
      cmd(C_REC, 3'd0);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL rec_when_full: err=%0b busy=%0b expected 1 0", err, busy);
      end
      cmd(C_DEL, 3'd5);
      n_checks++;
      if (err !== 1'b0 || used_mask !== 8'hDF || count !== 4'd7 || full !== 1'b0) begin
         n_errors++;
         $display("FAIL del5: err=%0b mask=%b count=%0d full=%0b expected 0 11011111 7 0",
                  err, used_mask, count, full);
      end
      cmd(C_REC, 3'd0);
      n_checks++;
      if (rec_slot !== 3'd5 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL realloc: slot=%0d busy=%0b expected 5 1", rec_slot, busy);
      end
   endtask

   task automatic test_overflow();
      wr_valid = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         wr_data = 8'(i);
         tick();
      end
      wr_valid = 1'b0;
      n_checks++;
      if (rec_len !== 9'd256 || overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL overflow: len=%0d ovf=%0b expected 256 1", rec_len, overflow);
      end
      cmd(C_DIS, 3'd0);
      n_checks++;
      if (busy !== 1'b0 || used_mask !== 8'hDF || count !== 4'd7) begin
         n_errors++;
         $display("FAIL rec_discard: busy=%0b mask=%b count=%0d expected 0 11011111 7", busy, used_mask, count);
      end
   endtask

   task automatic test_backpressure();
      push_slot3();
      rd_ready = 1'b0;
      cmd(C_PLAY, 3'd3);
      wait_valid("bp");
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== sb[0].data) begin
            n_errors++;
            $display("FAIL bp_hold: rdv=%0b data=%0h expected 1 %0h", rd_valid, rd_data, sb[0].data);
         end
      end
      cmd(C_REC, 3'd0);
      n_checks++;
      if (err !== 1'b1 || rd_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL rec_while_busy: err=%0b rdv=%0b expected 1 1", err, rd_valid);
      end
      drain("bp");
      finish_play("bp");
   endtask

   task automatic test_discard_play();
      rd_ready = 1'b1;
      cmd(C_PLAY, 3'd3);
      wait_valid("dp1");
      n_checks++;
      if (rd_data !== slot3_notes[0]) begin
         n_errors++;
         $display("FAIL dp_first: got %0h expected %0h", rd_data, slot3_notes[0]);
      end
      tick();
      rd_ready = 1'b0;
      wait_valid("dp2");
      n_checks++;
      if (rd_data !== slot3_notes[1] || rd_last !== 1'b0) begin
         n_errors++;
         $display("FAIL dp_second: data=%0h last=%0b expected %0h 0", rd_data, rd_last, slot3_notes[1]);
      end
      cmd(C_DIS, 3'd0);
      n_checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL dp_stop: rdv=%0b busy=%0b expected 0 0", rd_valid, busy);
      end
   endtask

   task automatic test_save_del_priority();
      exp_t e;
      cmd(C_REC, 3'd0);
      wr_valid = 1'b1;
      wr_data  = 8'h5A;
      e.data   = 8'h5A;
      e.last   = 1'b1;
      sb.push_back(e);
      sel      = 3'd6;
      cmd_save = 1'b1;
      cmd_del  = 1'b1;
      tick();
      {cmd_save, cmd_del, wr_valid} = 3'b0;
      n_checks++;
      if (err !== 1'b0 || used_mask !== 8'hFF || count !== 4'd8 || full !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL save_vs_del: err=%0b mask=%b count=%0d full=%0b busy=%0b expected 0 11111111 8 1 0",
                  err, used_mask, count, full, busy);
      end
      cmd(C_PLAY, 3'd5);
      drain("play5");
      finish_play("play5");
      cmd(C_DEL, 3'd7);
      cmd(C_REC, 3'd0);
      cmd(C_SAVE, 3'd0);
      n_checks++;
      if (count !== 4'd8 || used_mask !== 8'hFF) begin
         n_errors++;
         $display("FAIL empty_save: count=%0d mask=%b expected 8 11111111", count, used_mask);
      end
      cmd(C_PLAY, 3'd7);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL play_empty: err=%0b busy=%0b expected 1 0", err, busy);
      end
   endtask

`ifdef SONG_SLOT_BANK_LOOP_PLAY_EN
   task automatic test_loop_play();
      exp_t e;
      cmd(C_DEL, 3'd6);
      cmd(C_REC, 3'd0);
      write_note(8'hA1, 1'b0);
      write_note(8'hB2, 1'b1);
      cmd(C_SAVE, 3'd0);
      for (int i = 0; i < 2; i++) begin
         e.data = 8'hA1; e.last = 1'b0; sb.push_back(e);
         e.data = 8'hB2; e.last = 1'b1; sb.push_back(e);
      end
      cmd(C_PLAY, 3'd6);
      drain("loop");
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL loop_running: busy=%0b expected 1", busy);
      end
      finish_play("loop");
   endtask
`endif

   task automatic test_reset_mid_record();
      cmd(C_DEL, 3'd7);
      cmd(C_REC, 3'd0);
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      tick();
      wr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (used_mask !== 8'b00000111 || count !== 4'd3 || busy !== 1'b0 || rec_len !== 9'd0) begin
         n_errors++;
         $display("FAIL reset_mid_rec: mask=%b count=%0d busy=%0b len=%0d expected 00000111 3 0 0",
                  used_mask, count, busy, rec_len);
      end
      tick();
      rst_n = 1'b1;
      cmd(C_REC, 3'd0);
      n_checks++;
      if (rec_slot !== 3'd3) begin
         n_errors++;
         $display("FAIL rec_after_reset: slot=%0d expected 3", rec_slot);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {cmd_rec, cmd_save, cmd_discard, cmd_del, cmd_play} = 5'b0;
      sel = 3'd0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
      slot3_notes[0] = 8'h11;
      slot3_notes[1] = 8'h22;
      slot3_notes[2] = 8'h33;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      test_reset();
      test_record_play();
      test_fill_full();
      test_overflow();
      test_backpressure();
      test_discard_play();
      test_save_del_priority();
`ifdef SONG_SLOT_BANK_LOOP_PLAY_EN
      test_loop_play();
`endif
      test_reset_mid_record();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
